ysyx_24110015_axi_arbiter: RTL
==============================

YSYX_24110015_AXI_ARBITER -- requirements
Module: ysyx_24110015_axi_arbiter

Interface
REQ-001 SHALL have parameter IFU_ID, default 4'd0: value driven on arid toward the crossbar for IFU transactions.
REQ-002 SHALL have parameter LSU_ID, default 4'd1: value driven on arid/awid toward the crossbar for LSU transactions.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ifu, axi_lite_if.slave, interface: instruction-fetch master; read-only.
REQ-006 SHALL have port lsu, axi_lite_if.slave, interface: load/store master; read and write.
REQ-007 SHALL have port out, axi_lite_if.master, interface: shared downstream port to the crossbar.

Function
REQ-008 SHALL serve exactly one transaction at a time: one AR+R exchange, or one AW+W+B exchange.
REQ-009 SHALL use states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, and a registered grant {NONE, IFU, LSU}.
REQ-010 IDLE: requests are ifu.arvalid, lsu.arvalid and lsu.awvalid; a winner is granted at the clock edge where any request is present. Next state is RD_ADDR for a read or WR_REQ for a write. All ready/valid outputs are 0 while in IDLE.
REQ-011 LSU read and write requests present together: the read SHALL win.
REQ-012 ifu.awvalid and ifu.wvalid SHALL be ignored; ifu.awready, ifu.wready and ifu.bvalid SHALL be 0 at all times.
REQ-013 RD_ADDR: out.arvalid, araddr and arsize SHALL follow the granted master, and out.arid SHALL be the granted ID. The granted master's arready SHALL equal out.arready. Go to RD_DATA on out.arvalid & out.arready.
REQ-014 RD_DATA: out.rready SHALL equal the granted master's rready; rvalid, rdata and rresp SHALL be forwarded to the granted master only. Go to IDLE on out.rvalid & out.rready.
REQ-015 WR_REQ: out.awvalid/out.wvalid SHALL be forwarded from lsu, each gated by a registered done flag so that it deasserts after its own handshake. AW and W may complete in either order or in the same cycle. Go to WR_RESP when both flags are set, counting handshakes in the current cycle.
REQ-016 WR_RESP: bvalid/bresp SHALL be forwarded to lsu and out.bready SHALL equal lsu.bready. Go to IDLE on the B handshake; the done flags clear on that transition.
REQ-017 Any master not granted SHALL see every ready/valid input driven 0 and rdata/rresp/bresp driven 0.
REQ-018 Minimum gap SHALL be one IDLE cycle between the end of one transaction and the grant of the next; back-to-back requests therefore cost one extra cycle.
REQ-019 Address/data fields to out SHALL be muxed from the granted master. With grant NONE they SHALL be driven 0.
REQ-020 out.arlen/awlen SHALL be 0, arburst/awburst SHALL be INCR, and wstrb SHALL be forwarded from lsu.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, grant NONE, done flags 0, and all valid/ready outputs 0, both toward out and toward the masters.
REQ-022 Reset asserted mid-transaction SHALL abandon that transaction; no response is forwarded after rst_n rises.
REQ-023 After reset, the round-robin pointer (REQ-025) SHALL favour IFU.

Configuration
REQ-024 Without macro YSYX_24110015_ARB_RR_EN, arbitration SHALL be fixed priority: LSU over IFU.
REQ-025 With YSYX_24110015_ARB_RR_EN defined, arbitration SHALL be round-robin.
- A 1-bit last-grant register selects the winner on a simultaneous request: the master not granted last wins.
- The register updates at each grant.
- A lone requester always wins.

Verification
REQ-026 Scenario: IFU alone, ifu.araddr=0x8000_0000 → out.araddr=0x8000_0000, arid=0. R data 0x1234_5678 reaches ifu only. lsu sees rvalid=0.
REQ-027 Scenario: ifu.arvalid and lsu.arvalid rise in the same cycle.
- Fixed mode: LSU is served first, then IFU after a 1-cycle IDLE gap.
- RR mode after reset: IFU first, then LSU.
REQ-028 Scenario: LSU write, awaddr=0x0200_4000, wdata=0xDEAD_BEEF, wstrb=0xF; W handshakes 2 cycles before AW.
- Exactly one AW handshake and one W handshake occur.
- bresp=OKAY reaches lsu.
- out.wvalid is 0 after the W handshake.
REQ-029 Scenario: out.rvalid withheld 5 cycles while lsu.arvalid is pending → grant stays IFU, lsu.arready=0 throughout, and LSU is granted in the cycle after the IFU R handshake plus one IDLE cycle.
REQ-030 Scenario: rst_n pulled low in RD_DATA, then out.rvalid=1 after release → state is IDLE and ifu.rvalid=0; a new IFU read then completes normally.

Source files
------------

// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// rtl/ysyx_24110015_axi_arbiter_if.sv - single-beat AXI-lite style bundle shared by IFU, LSU and the crossbar port
interface axi_lite_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// rtl/ysyx_24110015_axi_arbiter.sv - one-at-a-time IFU/LSU arbiter onto a shared AXI-lite port
// Define YSYX_24110015_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module ysyx_24110015_axi_arbiter #(
  parameter logic [3:0] IFU_ID = 4'd0,
  parameter logic [3:0] LSU_ID = 4'd1
) (
  input  logic      clk,
  input  logic      rst_n,
  axi_lite_if.slave  ifu,
  axi_lite_if.slave  lsu,
  axi_lite_if.master out
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_IFU, GNT_LSU} grant_e;

  state_e state_q, state_d;
  grant_e grant_q, grant_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   ifu_req, lsu_req, pick_lsu;
  logic   gnt_ifu, gnt_lsu;
  logic   ar_fire, r_fire, aw_fire, w_fire, b_fire;

  assign gnt_ifu = (grant_q == GNT_IFU);
  assign gnt_lsu = (grant_q == GNT_LSU);
  assign ifu_req = ifu.arvalid;
  assign lsu_req = lsu.arvalid | lsu.awvalid;

`ifdef YSYX_24110015_ARB_RR_EN
  // last_lsu_q set means LSU won the previous grant, so IFU wins the next tie.
  logic last_lsu_q, last_lsu_d;
  assign pick_lsu = lsu_req & (~ifu_req | ~last_lsu_q);
`else
  assign pick_lsu = lsu_req;
`endif

  assign ar_fire = out.arvalid & out.arready;
  assign r_fire  = out.rvalid & out.rready;
  assign aw_fire = out.awvalid & out.awready;
  assign w_fire  = out.wvalid & out.wready;
  assign b_fire  = out.bvalid & out.bready;

  always_comb begin
    out.arvalid = 1'b0;
    out.araddr  = '0;
    out.arid    = '0;
    out.arsize  = '0;
    out.arlen   = 8'd0;
    out.arburst = 2'b01;
    out.rready  = 1'b0;
    out.awvalid = 1'b0;
    out.awaddr  = '0;
    out.awid    = '0;
    out.awsize  = '0;
    out.awlen   = 8'd0;
    out.awburst = 2'b01;
    out.wvalid  = 1'b0;
    out.wdata   = '0;
    out.wstrb   = '0;
    out.bready  = 1'b0;
    if (gnt_ifu) begin
      out.araddr = ifu.araddr;
      out.arsize = ifu.arsize;
      out.arid   = IFU_ID;
    end else if (gnt_lsu) begin
      out.araddr = lsu.araddr;
      out.arsize = lsu.arsize;
      out.arid   = LSU_ID;
      out.awaddr = lsu.awaddr;
      out.awsize = lsu.awsize;
      out.awid   = LSU_ID;
      out.wdata  = lsu.wdata;
      out.wstrb  = lsu.wstrb;
    end
    case (state_q)
      RD_ADDR: out.arvalid = gnt_lsu ? lsu.arvalid : ifu.arvalid;
      RD_DATA: out.rready  = gnt_lsu ? lsu.rready : ifu.rready;
      WR_REQ: begin
        out.awvalid = lsu.awvalid & ~aw_done_q;
        out.wvalid  = lsu.wvalid & ~w_done_q;
      end
      WR_RESP: out.bready = lsu.bready;
      default: ;
    endcase
  end

  always_comb begin
    ifu.arready = (state_q == RD_ADDR) & gnt_ifu & out.arready;
    ifu.rvalid  = (state_q == RD_DATA) & gnt_ifu & out.rvalid;
    ifu.rdata   = gnt_ifu ? out.rdata : '0;
    ifu.rresp   = gnt_ifu ? out.rresp : '0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bvalid  = 1'b0;
    ifu.bresp   = '0;
    lsu.arready = (state_q == RD_ADDR) & gnt_lsu & out.arready;
    lsu.rvalid  = (state_q == RD_DATA) & gnt_lsu & out.rvalid;
    lsu.rdata   = gnt_lsu ? out.rdata : '0;
    lsu.rresp   = gnt_lsu ? out.rresp : '0;
    lsu.awready = (state_q == WR_REQ) & ~aw_done_q & out.awready;
    lsu.wready  = (state_q == WR_REQ) & ~w_done_q & out.wready;
    lsu.bvalid  = (state_q == WR_RESP) & out.bvalid;
    lsu.bresp   = gnt_lsu ? out.bresp : '0;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q | aw_fire;
    w_done_d  = w_done_q | w_fire;
`ifdef YSYX_24110015_ARB_RR_EN
    last_lsu_d = last_lsu_q;
`endif
    case (state_q)
      IDLE: begin
        if (ifu_req | lsu_req) begin
          grant_d = pick_lsu ? GNT_LSU : GNT_IFU;
          state_d = (pick_lsu & ~lsu.arvalid) ? WR_REQ : RD_ADDR;
`ifdef YSYX_24110015_ARB_RR_EN
          last_lsu_d = pick_lsu;
`endif
        end
      end
      RD_ADDR: if (ar_fire) state_d = RD_DATA;
      RD_DATA: begin
        if (r_fire) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      end
      // The _d flags already include this cycle's handshakes.
      WR_REQ: if (aw_done_d & w_done_d) state_d = WR_RESP;
      WR_RESP: begin
        if (b_fire) begin
          state_d   = IDLE;
          grant_d   = GNT_NONE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef YSYX_24110015_ARB_RR_EN
      last_lsu_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef YSYX_24110015_ARB_RR_EN
      last_lsu_q <= last_lsu_d;
`endif
    end
  end
endmodule
